// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use interlock, branch flush, MEM-wait freeze
// with timeout to a sticky halt, plus saturating stall/flush performance counters.
module hazard_ctrl_unit #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rd_addr,
   input  logic             ex_branch_taken,
   input  logic             mem_access,
   input  logic             mem_ready,
   input  logic             stat_clear,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             pipeline_stall,
   output logic             id_ex_bubble,
   output logic             ex_mem_stall,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);

   localparam int unsigned WAIT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                mem_pending;
   logic                freeze;
   logic                load_use;
   logic                stall_inc;

   assign mem_pending = mem_access & ~mem_ready;
   assign freeze      = mem_pending | (state == HALT);

   assign load_use = ex_mem_read & (ex_rd_addr != 5'd0) &
                     ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                      (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

   // Freeze holds EX, so a pending branch is simply re-seen once freeze drops.
   always_comb begin
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      if_id_flush    = 1'b0;
      pipeline_stall = 1'b0;
      id_ex_bubble   = 1'b0;
      ex_mem_stall   = 1'b0;
      if (freeze) begin
         pc_write       = 1'b0;
         if_id_write    = 1'b0;
         pipeline_stall = 1'b1;
         ex_mem_stall   = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush    = 1'b1;
         id_ex_bubble   = 1'b1;
      end else if (load_use) begin
         pc_write       = 1'b0;
         if_id_write    = 1'b0;
         id_ex_bubble   = 1'b1;
      end
   end

   assign stall_inc = ~pc_write & (state != HALT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= RUN;
         wait_cnt <= '0;
         halted   <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mem_pending) begin
                  state    <= MEM_WAIT;
                  wait_cnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (!mem_pending) begin
                  state    <= RUN;
                  wait_cnt <= '0;
               end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES)) begin
                  state  <= HALT;
                  halted <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + WAIT_W'(1);
               end
            end
            HALT: begin
               state  <= HALT;
               halted <= 1'b1;
            end
            default: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else if (stat_clear) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (stall_inc && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (if_id_flush && (flush_count != '1))
            flush_count <= flush_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit (TIMEOUT_CYCLES=4, CNT_W=4): expected
// outputs are queued as each cycle is driven and compared at the falling edge.
module tb_hazard_ctrl_unit;

   localparam int unsigned TO  = 4;
   localparam int unsigned CW  = 4;
   localparam logic [CW-1:0] SAT = '1;

   // {pc_write, if_id_write, if_id_flush, pipeline_stall, id_ex_bubble, ex_mem_stall}
   localparam logic [5:0] NORM = 6'b110000;
   localparam logic [5:0] FRZ  = 6'b000101;
   localparam logic [5:0] BR   = 6'b111010;
   localparam logic [5:0] LU   = 6'b000010;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic       exr;
      logic [4:0] exrd;
      logic       br;
      logic       ma;
      logic       mr;
      logic       sc;
   } vec_t;

   typedef struct packed {
      logic [5:0]    ctrl;
      logic          halt;
      logic [CW-1:0] stall;
      logic [CW-1:0] flush;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic          id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic          mem_access, mem_ready, stat_clear;
   logic          pc_write, if_id_write, if_id_flush, pipeline_stall, id_ex_bubble, ex_mem_stall;
   logic          halted;
   logic [CW-1:0] stall_cycles, flush_count;

   exp_t          sb[$];
   int unsigned   n_vec = 0;
   int unsigned   n_err = 0;
   logic [CW-1:0] exp_stall = '0;
   logic [CW-1:0] exp_flush = '0;
   vec_t          idle = '0;

   hazard_ctrl_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
      .ex_branch_taken(ex_branch_taken),
      .mem_access(mem_access), .mem_ready(mem_ready), .stat_clear(stat_clear),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .pipeline_stall(pipeline_stall), .id_ex_bubble(id_ex_bubble),
      .ex_mem_stall(ex_mem_stall), .halted(halted),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic exr,
                               input logic [4:0] exrd, input logic br,
                               input logic ma, input logic mr, input logic sc);
      vec_t v;
      v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exr = exr;
      v.exrd = exrd; v.br = br; v.ma = ma; v.mr = mr; v.sc = sc;
      return v;
   endfunction

   function automatic vec_t memv(input logic ma, input logic mr, input logic br);
      return mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, br, ma, mr, 1'b0);
   endfunction

   task automatic apply(input vec_t v);
      id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
      id_uses_rs1 = v.u1;  id_uses_rs2 = v.u2;
      ex_mem_read = v.exr; ex_rd_addr  = v.exrd;
      ex_branch_taken = v.br;
      mem_access = v.ma; mem_ready = v.mr; stat_clear = v.sc;
   endtask

   // One cycle: drive, queue expectation, then advance the counter expectations
   // by what this cycle's expected controls imply at the coming edge.
   task automatic drive(input vec_t v, input logic [5:0] exp_ctrl, input logic exp_halt);
      exp_t e;
      @(posedge clk); #1;
      apply(v);
      e.ctrl = exp_ctrl; e.halt = exp_halt; e.stall = exp_stall; e.flush = exp_flush;
      sb.push_back(e);
      if (v.sc) begin
         exp_stall = '0;
         exp_flush = '0;
      end else begin
         if (!exp_ctrl[5] && !exp_halt && exp_stall != SAT) exp_stall = exp_stall + 1'b1;
         if (exp_ctrl[3] && exp_flush != SAT) exp_flush = exp_flush + 1'b1;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      apply(idle);
      rst = 1'b1;
      #2;
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_stall", {28'd0, stall_cycles}, 32'd0);
      check("rst_flush", {28'd0, flush_count}, 32'd0);
      check("rst_ctrl", {26'd0, pc_write, if_id_write, if_id_flush, pipeline_stall,
                         id_ex_bubble, ex_mem_stall}, {26'd0, NORM});
      @(negedge clk); #1;
      rst = 1'b0;
      exp_stall = '0;
      exp_flush = '0;
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("ctrl", {26'd0, pc_write, if_id_write, if_id_flush, pipeline_stall,
                        id_ex_bubble, ex_mem_stall}, {26'd0, e.ctrl});
         check("halted", {31'd0, halted}, {31'd0, e.halt});
         check("stall_cycles", {28'd0, stall_cycles}, {28'd0, e.stall});
         check("flush_count", {28'd0, flush_count}, {28'd0, e.flush});
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b0;
      apply(idle);
      do_reset();
      drive(idle, NORM, 1'b0);
      drive(idle, NORM, 1'b0);

      // load-use on rs2, then on rs1; non-hazards: x0, unused operand, non-load
      drive(mk(5'd1, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0), LU, 1'b0);
      drive(idle, NORM, 1'b0);
      drive(mk(5'd7, 5'd2, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0), LU, 1'b0);
      drive(mk(5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0), NORM, 1'b0);
      drive(mk(5'd9, 5'd3, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0), NORM, 1'b0);
      drive(mk(5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0), NORM, 1'b0);

      // branch wins over load-use
      drive(mk(5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), BR, 1'b0);
      drive(idle, NORM, 1'b0);

      // 3-cycle memory wait, then a branch held through a freeze
      drive(memv(1'b1, 1'b0, 1'b0), FRZ, 1'b0);
      drive(memv(1'b1, 1'b0, 1'b0), FRZ, 1'b0);
      drive(memv(1'b1, 1'b0, 1'b0), FRZ, 1'b0);
      drive(memv(1'b1, 1'b1, 1'b0), NORM, 1'b0);
      drive(memv(1'b1, 1'b0, 1'b1), FRZ, 1'b0);
      drive(memv(1'b1, 1'b1, 1'b1), BR, 1'b0);
      drive(idle, NORM, 1'b0);

      // counter clear
      drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), NORM, 1'b0);
      drive(idle, NORM, 1'b0);

      // timeout: 5 freeze cycles then sticky halt
      for (int unsigned i = 0; i < TO + 1; i++) drive(memv(1'b1, 1'b0, 1'b0), FRZ, 1'b0);
      drive(memv(1'b1, 1'b1, 1'b0), FRZ, 1'b1);
      drive(mk(5'd4, 5'd4, 1'b1, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0), FRZ, 1'b1);
      drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1), FRZ, 1'b1);
      drive(idle, FRZ, 1'b1);
      do_reset();
      drive(idle, NORM, 1'b0);

      // reset mid-wait leaves no residue; full timeout count restarts from RUN
      drive(memv(1'b1, 1'b0, 1'b0), FRZ, 1'b0);
      drive(memv(1'b1, 1'b0, 1'b0), FRZ, 1'b0);
      do_reset();
      drive(idle, NORM, 1'b0);
      for (int unsigned i = 0; i < TO + 1; i++) drive(memv(1'b1, 1'b0, 1'b0), FRZ, 1'b0);
      drive(idle, FRZ, 1'b1);
      do_reset();

      // saturation of both counters, then clear concurrent with a flush
      for (int unsigned i = 0; i < 20; i++) drive(memv(1'b0, 1'b0, 1'b1), BR, 1'b0);
      for (int unsigned i = 0; i < 20; i++)
         drive(mk(5'd6, 5'd0, 1'b1, 1'b0, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0), LU, 1'b0);
      drive(idle, NORM, 1'b0);
      drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), BR, 1'b0);
      drive(idle, NORM, 1'b0);
      drive(idle, NORM, 1'b0);

      @(negedge clk); #1;
      check("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of consecutive MEM wait cycles before a fatal halt.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the performance counters.
REQ-003 The block SHALL have port clk  in  1  clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have ports id_rs1_addr, id_rs2_addr  in  5 each  source registers of the instruction in ID.
REQ-006 The block SHALL have ports id_uses_rs1, id_uses_rs2  in  1 each  qualifiers that the ID instruction reads rs1/rs2.
REQ-007 The block SHALL have ports ex_mem_read  in  1  and ex_rd_addr  in  5  describing the instruction currently in EX.
REQ-008 The block SHALL have port ex_branch_taken  in  1  meaning the EX-stage branch/jump redirects the PC.
REQ-009 The block SHALL have ports mem_access  in  1  (MEM stage has an active data access) and mem_ready  in  1  (data memory completes the access this cycle).
REQ-010 The block SHALL have port stat_clear  in  1  synchronous clear of the performance counters.
REQ-011 The block SHALL have outputs pc_write, if_id_write, if_id_flush  out  1 each  controlling the PC and IF/ID register.
REQ-012 The block SHALL have outputs pipeline_stall  out  1  (ID/EX hold), id_ex_bubble  out  1  (ID/EX loads all-zero controls), and ex_mem_stall  out  1  (EX/MEM and MEM/WB hold).
REQ-013 The block SHALL have outputs halted  out  1  (sticky timeout error), stall_cycles  out  CNT_W, and flush_count  out  CNT_W.

Function
REQ-014 freeze SHALL be defined as (mem_access & ~mem_ready) | (state == HALT).
REQ-015 load_use SHALL be defined as ex_mem_read & (ex_rd_addr != 0) & ((id_uses_rs1 & id_rs1_addr == ex_rd_addr) | (id_uses_rs2 & id_rs2_addr == ex_rd_addr)).
REQ-016 Output priority SHALL be freeze > ex_branch_taken > load_use > normal, and all control outputs SHALL be combinational from the current state and inputs.
REQ-017 Under freeze: pc_write=0, if_id_write=0, if_id_flush=0, pipeline_stall=1, id_ex_bubble=0, ex_mem_stall=1.
REQ-018 Under branch (no freeze): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1, pipeline_stall=0, ex_mem_stall=0, and load_use SHALL be ignored.
REQ-019 Under load_use (no freeze, no branch): pc_write=0, if_id_write=0, id_ex_bubble=1, and if_id_flush=pipeline_stall=ex_mem_stall=0.
REQ-020 Normal operation: pc_write=1, if_id_write=1, and all other control outputs 0.
REQ-021 A branch that occurs during freeze SHALL NOT be lost: ex_branch_taken stays held by the frozen EX stage and SHALL be acted on in the first cycle freeze deasserts.
REQ-022 The FSM SHALL have states RUN, MEM_WAIT, and HALT.
REQ-023 FSM transition from RUN: mem_access & ~mem_ready -> MEM_WAIT with wait_cnt=1; otherwise stay in RUN.
REQ-024 FSM transitions from MEM_WAIT: mem_ready or ~mem_access -> RUN with wait_cnt=0; else if wait_cnt == TIMEOUT_CYCLES -> HALT; else wait_cnt+1.
REQ-025 The FSM SHALL remain in HALT until rst, with halted=1 and freeze forced.
REQ-026 wait_cnt width SHALL be clog2(TIMEOUT_CYCLES+1), and freeze SHALL last at most TIMEOUT_CYCLES+1 cycles before HALT.
REQ-027 stall_cycles SHALL increment by 1 each cycle that freeze or load_use stalls the PC, excluding HALT cycles, and SHALL saturate at all-ones.
REQ-028 flush_count SHALL increment by 1 each cycle if_id_flush=1 and SHALL saturate at all-ones.
REQ-029 stat_clear SHALL zero both counters on the next edge, take priority over an increment in the same cycle, and leave the FSM unaffected.
REQ-030 Register x0 SHALL never create a load-use hazard.

Reset
REQ-031 On rst, asynchronously: state=RUN, wait_cnt=0, halted=0, stall_cycles=0, flush_count=0.
REQ-032 With no hazard inputs during and after rst, outputs SHALL be pc_write=1, if_id_write=1, and all others 0.
REQ-033 rst asserted mid MEM_WAIT or in HALT SHALL return the FSM to RUN immediately, with no residual stall.

Verification
REQ-034 Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_bubble=1, stall_cycles=1.
REQ-035 x0 and unused operand: ex_rd=0, or id_uses_rs1=0 with matching address -> no stall, pc_write=1.
REQ-036 Branch plus load_use in the same cycle -> if_id_flush=1, id_ex_bubble=1, pc_write=1, flush_count +1, stall_cycles unchanged.
REQ-037 mem_access=1 with mem_ready low for 3 cycles, then high -> pipeline_stall=ex_mem_stall=1 for exactly 3 cycles, stall_cycles=3, state back to RUN.
REQ-038 TIMEOUT_CYCLES=4 with mem_ready held low -> halted=1 after 5 freeze cycles and stays 1 after mem_ready rises; rst clears it.
REQ-039 Counters with CNT_W=4: 20 flushes -> flush_count=15; stat_clear concurrent with a flush -> flush_count=0.
